dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port data memory (DMEM) between two requesters.
- Port 0 is the CPU load/store unit. Port 1 is the loader/debug port, which preloads and inspects DMEM while the CPU runs.
- Sits between the requesters and the DMEM macro.
- Issues at most one memory access per cycle and routes synchronous read data back to the requester that issued the read.

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-port DMEM between the CPU (port 0) and the loader/debug port (port 1).
// Optional macro DMEM_ARB_RR_EN switches contention handling from fixed m0 priority to round-robin.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_DATA_WIDTH = 32,
  parameter int BE_WIDTH        = DMEM_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m0_req,
  input  logic                       m0_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] m0_addr,
  input  logic [DMEM_DATA_WIDTH-1:0] m0_wdata,
  input  logic [BE_WIDTH-1:0]        m0_be,
  output logic                       m0_gnt,
  output logic                       m0_rvalid,
  output logic [DMEM_DATA_WIDTH-1:0] m0_rdata,
  input  logic                       m1_req,
  input  logic                       m1_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] m1_addr,
  input  logic [DMEM_DATA_WIDTH-1:0] m1_wdata,
  input  logic [BE_WIDTH-1:0]        m1_be,
  input  logic                       m1_lock,
  output logic                       m1_gnt,
  output logic                       m1_rvalid,
  output logic [DMEM_DATA_WIDTH-1:0] m1_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DMEM_DATA_WIDTH-1:0] mem_wdata,
  output logic [BE_WIDTH-1:0]        mem_be,
  input  logic [DMEM_DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {ARB, LOCK1} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   rd_pending_q, rd_pending_d;
  logic   rd_owner_q, rd_owner_d;
  logic   arb_mode;
  logic   m1_wins_tie;

  always_comb begin
    // Dropping m1_lock while locked hands arbitration back to the normal rules in the same cycle.
    arb_mode = (state_q == ARB) || !m1_lock;
`ifdef DMEM_ARB_RR_EN
    m1_wins_tie = !last_grant_q;
`else
    m1_wins_tie = 1'b0 && !last_grant_q;
`endif
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      if (arb_mode) begin
        if (m0_req && m1_req) begin
          m0_gnt = !m1_wins_tie;
          m1_gnt = m1_wins_tie;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req;
        end
      end else begin
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    mem_en    = m0_gnt | m1_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_be    = m0_be;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_be    = m1_be;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (arb_mode) begin
      state_d = (m1_gnt && m1_lock) ? LOCK1 : ARB;
    end
    if (m0_gnt) begin
      last_grant_d = 1'b0;
    end else if (m1_gnt) begin
      last_grant_d = 1'b1;
    end
    rd_pending_d = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    rd_owner_d   = rd_pending_d ? m1_gnt : rd_owner_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Only the port that issued the read ever sees memory data.
  assign m0_rvalid = rd_pending_q && !rd_owner_q;
  assign m1_rvalid = rd_pending_q && rd_owner_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural byte-enabled synchronous DMEM.
// Contention expectations follow DMEM_ARB_RR_EN when the bench is built with that macro.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [11:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
  logic [11:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] mem [0:4095];
  int          checks;
  int          failures;
  logic        exp_m1;
  logic        prev_m1;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port DMEM: byte-enabled write, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0, input logic [3:0] b0,
    input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1, input logic [3:0] b1,
    input logic lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_be = b0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_be = b1;
    m1_lock = lk;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    mem_rdata = '0;
    applyStimulus(1, 0, 12'h010, 0, 4'hF, 1, 0, 12'h020, 0, 4'hF, 0);

    // Requests during reset must not be granted.
    @(negedge clk);
    checkOutput("rst_m0_gnt", {31'b0, m0_gnt}, 0);
    checkOutput("rst_m1_gnt", {31'b0, m1_gnt}, 0);
    checkOutput("rst_mem_en", {31'b0, mem_en}, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_m0_gnt", {31'b0, m0_gnt}, 0);
    checkOutput("idle_m1_gnt", {31'b0, m1_gnt}, 0);
    checkOutput("idle_mem_en", {31'b0, mem_en}, 0);
    checkOutput("idle_m0_rvalid", {31'b0, m0_rvalid}, 0);
    checkOutput("idle_m1_rvalid", {31'b0, m1_rvalid}, 0);
    nextCycle();

    // m0 write then read-back.
    applyStimulus(1, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wr_m0_gnt", {31'b0, m0_gnt}, 1);
    checkOutput("wr_mem_we", {31'b0, mem_we}, 1);
    checkOutput("wr_mem_addr", {20'b0, mem_addr}, 32'h010);
    checkOutput("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(1, 0, 12'h010, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd_m0_gnt", {31'b0, m0_gnt}, 1);
    checkOutput("rd_mem_we", {31'b0, mem_we}, 0);
    checkOutput("wr_no_rvalid", {31'b0, m0_rvalid}, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd_m0_rvalid", {31'b0, m0_rvalid}, 1);
    checkOutput("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_m1_rvalid", {31'b0, m1_rvalid}, 0);
    checkOutput("rd_m1_rdata", m1_rdata, 0);
    nextCycle();

    // m1 preloads a second word.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 12'h020, 32'hA5A50001, 4'hF, 0);
    @(negedge clk);
    checkOutput("m1_wr_gnt", {31'b0, m1_gnt}, 1);
    checkOutput("m1_wr_addr", {20'b0, mem_addr}, 32'h020);
    nextCycle();

    // Four cycles of contention.
    prev_m1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_m1 = (i % 2) == 1;
`else
      exp_m1 = 1'b0;
`endif
      applyStimulus(1, 0, 12'h010, 0, 4'hF, 1, 0, 12'h020, 0, 4'hF, 0);
      @(negedge clk);
      checkOutput("cont_m0_gnt", {31'b0, m0_gnt}, {31'b0, !exp_m1});
      checkOutput("cont_m1_gnt", {31'b0, m1_gnt}, {31'b0, exp_m1});
      if (i > 0) begin
        checkOutput("cont_m0_rvalid", {31'b0, m0_rvalid}, {31'b0, !prev_m1});
        checkOutput("cont_m1_rvalid", {31'b0, m1_rvalid}, {31'b0, prev_m1});
        checkOutput("cont_m0_rdata", m0_rdata, prev_m1 ? 32'h0 : 32'hDEADBEEF);
        checkOutput("cont_m1_rdata", m1_rdata, prev_m1 ? 32'hA5A50001 : 32'h0);
      end else begin
        checkOutput("cont_first_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 0);
      end
      prev_m1 = exp_m1;
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("cont_last_m1_rvalid", {31'b0, m1_rvalid}, {31'b0, prev_m1});
    checkOutput("cont_last_m0_rvalid", {31'b0, m0_rvalid}, {31'b0, !prev_m1});
    nextCycle();

    // Lock sequence: m1 acquires, idles while locked, reads under contention, then releases.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h020, 0, 4'hF, 1);
    @(negedge clk);
    checkOutput("lk_acq_m1_gnt", {31'b0, m1_gnt}, 1);
    nextCycle();
    applyStimulus(1, 0, 12'h010, 0, 4'hF, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lk_idle_m0_gnt", {31'b0, m0_gnt}, 0);
    checkOutput("lk_idle_m1_gnt", {31'b0, m1_gnt}, 0);
    checkOutput("lk_idle_mem_en", {31'b0, mem_en}, 0);
    checkOutput("lk_acq_m1_rdata", m1_rdata, 32'hA5A50001);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 12'h010, 0, 4'hF, 1, 0, 12'h020, 0, 4'hF, 1);
      @(negedge clk);
      checkOutput("lk_m0_gnt", {31'b0, m0_gnt}, 0);
      checkOutput("lk_m1_gnt", {31'b0, m1_gnt}, 1);
      if (i > 0) begin
        checkOutput("lk_m1_rdata", m1_rdata, 32'hA5A50001);
        checkOutput("lk_m0_rdata", m0_rdata, 0);
      end
      nextCycle();
    end
    applyStimulus(1, 0, 12'h010, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("unlk_m0_gnt", {31'b0, m0_gnt}, 1);
    checkOutput("unlk_m1_gnt", {31'b0, m1_gnt}, 0);
    checkOutput("unlk_m1_rvalid", {31'b0, m1_rvalid}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("unlk_m0_rdata", m0_rdata, 32'hDEADBEEF);
    nextCycle();

    // Lock without request in ARB has no effect; partial write merges one byte.
    applyStimulus(1, 1, 12'h030, 32'h11223344, 4'hF, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lk_noreq_m0_gnt", {31'b0, m0_gnt}, 1);
    nextCycle();
    applyStimulus(1, 1, 12'h030, 32'h0000AB00, 4'b0010, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pw_m0_gnt", {31'b0, m0_gnt}, 1);
    checkOutput("pw_mem_be", {28'b0, mem_be}, 32'h2);
    nextCycle();
    applyStimulus(1, 0, 12'h030, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pw_rd_gnt", {31'b0, m0_gnt}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pw_rdata", m0_rdata, 32'h1122AB44);
    nextCycle();

    // Back-to-back reads alternating ports without contention.
    applyStimulus(1, 0, 12'h010, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h020, 0, 4'hF, 0);
    @(negedge clk);
    checkOutput("alt_m1_gnt", {31'b0, m1_gnt}, 1);
    checkOutput("alt_m0_rdata", m0_rdata, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("alt_m1_rdata", m1_rdata, 32'hA5A50001);
    checkOutput("alt_m0_rvalid", {31'b0, m0_rvalid}, 0);
    nextCycle();

    // Reset lands between a read grant and its data.
    applyStimulus(1, 0, 12'h010, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rr_gnt", {31'b0, m0_gnt}, 1);
    @(posedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rr_in_rst_rvalid", {31'b0, m0_rvalid}, 0);
    nextCycle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rr_post_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 0);
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
